// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Next-PC and call-stack unit ahead of fetch/decode. Each cycle it inspects
//   the instruction word at instrmem[pc] and produces the next fetch address.
//   It resolves jump / call / ret (and the OPaddr word that follows a control
//   word), and stalls fetch on jumpf until the PE reports the condition.
//
//   Optional feature macro: PCSEQ_STACK_ERR_EN
//     defined   : err is set on stack overflow, ret underflow or a malformed
//                 OPaddr word. Once err=1 all state freezes (like halt) and
//                 stall=1 until reset.
//     undefined : err stays 0. Overflow silently drops the oldest entry,
//                 an underflowing ret and a malformed OPaddr word fall
//                 through to pc+1.
//
// Ports
//   clk         in   1        rising-edge clock
//   reset       in   1        asynchronous active-low reset
//   halt        in   1        1 = hold every register
//   ir          in   WIDTH    instruction word at instrmem[pc]
//   cond_valid  in   1        jumpf condition valid (only looked at in WAIT)
//   cond_zero   in   1        jumpf operand was zero -> branch taken
//   pc          out  WIDTH    fetch address
//   stall       out  1        fetch must issue OPnop this cycle
//   depth       out  DEPTH_W  entries on the call stack
//   err         out  1        sticky error flag
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned DEPTH_W     = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               halt,
    input  logic [WIDTH-1:0]   ir,
    input  logic               cond_valid,
    input  logic               cond_zero,
    output logic [WIDTH-1:0]   pc,
    output logic               stall,
    output logic [DEPTH_W-1:0] depth,
    output logic               err
);

`ifdef PCSEQ_STACK_ERR_EN
    localparam logic ERR_EN_C = 1'b1;
`else
    localparam logic ERR_EN_C = 1'b0;
`endif

    localparam int unsigned IDX_W = DEPTH_W - 1;

    localparam logic [WIDTH-1:0]   PC_ONE_C     = WIDTH'(1'b1);
    localparam logic [WIDTH-1:0]   PC_TWO_C     = WIDTH'(2'd2);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE_C  = DEPTH_W'(1'b1);
    localparam logic [DEPTH_W-1:0] DEPTH_FULL_C = DEPTH_W'(STACK_DEPTH);
    localparam logic [IDX_W-1:0]   IDX_ONE_C    = IDX_W'(1'b1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        K_NONE  = 2'd0,
        K_JUMP  = 2'd1,
        K_CALL  = 2'd2,
        K_JUMPF = 2'd3
    } kind_t;

    state_t             state_r;
    state_t             state_nx_s;
    kind_t              kind_r;
    kind_t              kind_nx_s;
    logic [7:0]         lo_r;
    logic [7:0]         lo_nx_s;
    logic [7:0]         hi_r;
    logic [7:0]         hi_nx_s;
    logic [WIDTH-1:0]   pc_nx_s;
    logic               push_s;
    logic               pop_s;
    logic               err_set_s;
    logic               hold_s;
    logic [WIDTH-1:0]   stack_r [STACK_DEPTH];

    logic [3:0]         op_s;
    logic               is_ret_s;
    logic               is_addr_s;
    logic               full_s;
    logic               empty_s;
    logic [IDX_W-1:0]   top_idx_s;
    logic [WIDTH-1:0]   top_s;
    logic [WIDTH-1:0]   push_val_s;
    logic [WIDTH-1:0]   target_s;
    logic               unused_ir_s;

    assign op_s        = ir[15:12];
    assign is_ret_s    = (op_s == 4'h0) && (ir[3:0] == 4'h1);
    assign is_addr_s   = (op_s == 4'hF);
    assign unused_ir_s = ^ir[11:8];

    assign full_s      = (depth == DEPTH_FULL_C);
    assign empty_s     = (depth == {DEPTH_W{1'b0}});
    assign top_idx_s   = depth[IDX_W-1:0] - IDX_ONE_C;
    assign top_s       = stack_r[top_idx_s];
    // pc points at the OPaddr word when a call is resolved; the call word is one before.
    assign push_val_s  = pc - PC_ONE_C;
    // In WAIT the high byte comes from the latched OPaddr word so ir may change freely.
    assign target_s    = (state_r == ST_WAIT) ? WIDTH'({hi_r, lo_r}) : WIDTH'({ir[7:0], lo_r});

    // A raised err freezes the sequencer exactly like halt.
    assign hold_s      = halt | err;
    assign stall       = (state_r == ST_WAIT) | err;

    // Next-state, next-pc and stack control decode.
    always_comb begin
        state_nx_s = state_r;
        kind_nx_s  = kind_r;
        lo_nx_s    = lo_r;
        hi_nx_s    = hi_r;
        pc_nx_s    = pc;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        err_set_s  = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (is_ret_s) begin
                    if (!empty_s) begin
                        pc_nx_s = top_s + PC_TWO_C;
                        pop_s   = 1'b1;
                    end else begin
                        pc_nx_s   = pc + PC_ONE_C;
                        err_set_s = 1'b1;
                    end
                end else if ((op_s == 4'hC) || (op_s == 4'hD) || (op_s == 4'hE)) begin
                    lo_nx_s    = ir[7:0];
                    pc_nx_s    = pc + PC_ONE_C;
                    state_nx_s = ST_ADDR;
                    case (op_s)
                        4'hC:    kind_nx_s = K_CALL;
                        4'hD:    kind_nx_s = K_JUMP;
                        default: kind_nx_s = K_JUMPF;
                    endcase
                end else begin
                    pc_nx_s = pc + PC_ONE_C;
                end
            end
            ST_ADDR: begin
                if (!is_addr_s) begin
                    // Malformed address word: drop the control word and move on.
                    err_set_s  = 1'b1;
                    pc_nx_s    = pc + PC_ONE_C;
                    state_nx_s = ST_RUN;
                end else begin
                    case (kind_r)
                        K_JUMP: begin
                            pc_nx_s    = target_s;
                            state_nx_s = ST_RUN;
                        end
                        K_CALL: begin
                            push_s     = 1'b1;
                            err_set_s  = full_s;
                            pc_nx_s    = target_s;
                            state_nx_s = ST_RUN;
                        end
                        K_JUMPF: begin
                            hi_nx_s    = ir[7:0];
                            state_nx_s = ST_WAIT;
                        end
                        default: begin
                            pc_nx_s    = pc + PC_ONE_C;
                            state_nx_s = ST_RUN;
                        end
                    endcase
                end
            end
            ST_WAIT: begin
                if (cond_valid) begin
                    pc_nx_s    = cond_zero ? target_s : (pc + PC_ONE_C);
                    state_nx_s = ST_RUN;
                end else begin
                    pc_nx_s = pc;
                end
            end
            default: begin
                state_nx_s = ST_RUN;
            end
        endcase
    end

    // Control registers: pc, FSM state, pending control word, depth and err.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_RUN;
            kind_r  <= K_NONE;
            lo_r    <= 8'h00;
            hi_r    <= 8'h00;
            pc      <= {WIDTH{1'b0}};
            depth   <= {DEPTH_W{1'b0}};
            err     <= 1'b0;
        end else if (!hold_s) begin
            state_r <= state_nx_s;
            kind_r  <= kind_nx_s;
            lo_r    <= lo_nx_s;
            hi_r    <= hi_nx_s;
            pc      <= pc_nx_s;
            if (push_s && !full_s) begin
                depth <= depth + DEPTH_ONE_C;
            end else if (pop_s) begin
                depth <= depth - DEPTH_ONE_C;
            end
            err     <= err | (ERR_EN_C & err_set_s);
        end
    end

    // Call stack storage; a push into a full stack shifts out the oldest entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_r[i] <= {WIDTH{1'b0}};
            end
        end else if (!hold_s && push_s) begin
            if (full_s) begin
                for (int i = 0; i < STACK_DEPTH - 1; i++) begin
                    stack_r[i] <= stack_r[i + 1];
                end
                stack_r[STACK_DEPTH - 1] <= push_val_s;
            end else begin
                stack_r[depth[IDX_W-1:0]] <= push_val_s;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//   Directed bench for pc_sequencer: plain fetch, jump, call/ret, jumpf with
//   both condition outcomes, stack overflow/underflow, halt and async reset
//   in WAIT, pc wrap and a malformed OPaddr word. Expected values are
//   hand-computed; outputs are sampled 1 time unit after the rising edge.
//   Honours PCSEQ_STACK_ERR_EN so the same bench fits both builds.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

`ifdef PCSEQ_STACK_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic        halt       = 1'b0;
    logic [15:0] ir         = 16'h1000;
    logic        cond_valid = 1'b0;
    logic        cond_zero  = 1'b0;
    logic [15:0] pc;
    logic        stall;
    logic [2:0]  depth;
    logic        err;

    int checks   = 0;
    int failures = 0;

    pc_sequencer #(
        .WIDTH       (16),
        .STACK_DEPTH (4),
        .DEPTH_W     (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .halt       (halt),
        .ir         (ir),
        .cond_valid (cond_valid),
        .cond_zero  (cond_zero),
        .pc         (pc),
        .stall      (stall),
        .depth      (depth),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] e_pc, input logic e_stall,
                           input logic [2:0] e_depth, input logic e_err);
        chk({tag, ".pc"},    pc,              e_pc);
        chk({tag, ".stall"}, {15'd0, stall},  {15'd0, e_stall});
        chk({tag, ".depth"}, {13'd0, depth},  {13'd0, e_depth});
        chk({tag, ".err"},   {15'd0, err},    {15'd0, e_err});
    endtask

    task automatic step(input logic [15:0] word);
        ir = word;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #3;
        chk_all("reset", 16'h0000, 1'b0, 3'd0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // 1: plain words advance pc by one
        chk_all("t1_pc0", 16'h0000, 1'b0, 3'd0, 1'b0);
        step(16'h1000); chk_all("t1_pc1", 16'h0001, 1'b0, 3'd0, 1'b0);
        step(16'h1000); chk_all("t1_pc2", 16'h0002, 1'b0, 3'd0, 1'b0);
        step(16'h1000); chk_all("t1_pc3", 16'h0003, 1'b0, 3'd0, 1'b0);
        step(16'h1000); chk("t1_pc4", pc, 16'h0004);

        // 2: jump D034 / F012
        step(16'hD034); chk_all("t2_ctl",  16'h0005, 1'b0, 3'd0, 1'b0);
        step(16'hF012); chk_all("t2_jump", 16'h1234, 1'b0, 3'd0, 1'b0);

        // 3: reach pc=10, then call C056/F000 and ret
        step(16'hD00A); chk("t3_pre1", pc, 16'h1235);
        step(16'hF000); chk("t3_pre2", pc, 16'h000A);
        step(16'hC056); chk_all("t3_ctl",  16'h000B, 1'b0, 3'd0, 1'b0);
        step(16'hF000); chk_all("t3_call", 16'h0056, 1'b0, 3'd1, 1'b0);
        step(16'h0001); chk_all("t3_ret",  16'h000C, 1'b0, 3'd0, 1'b0);

        // 4a: jumpf taken after three idle WAIT cycles
        step(16'hE078); chk_all("t4_ctl",  16'h000D, 1'b0, 3'd0, 1'b0);
        step(16'hF001); chk_all("t4_wait", 16'h000D, 1'b1, 3'd0, 1'b0);
        step(16'hF001); chk_all("t4_w1",   16'h000D, 1'b1, 3'd0, 1'b0);
        step(16'hF001); chk_all("t4_w2",   16'h000D, 1'b1, 3'd0, 1'b0);
        step(16'hF001); chk_all("t4_w3",   16'h000D, 1'b1, 3'd0, 1'b0);
        cond_valid = 1'b1; cond_zero = 1'b1;
        step(16'hF001); chk_all("t4_taken", 16'h0178, 1'b0, 3'd0, 1'b0);

        // 4b: jumpf not taken; cond_valid held high through RUN/ADDR is ignored
        cond_zero = 1'b0;
        step(16'hE078); chk_all("t4b_ctl",  16'h0179, 1'b0, 3'd0, 1'b0);
        step(16'hF001); chk_all("t4b_wait", 16'h0179, 1'b1, 3'd0, 1'b0);
        step(16'hF001); chk_all("t4b_nt",   16'h017A, 1'b0, 3'd0, 1'b0);
        cond_valid = 1'b0;

        // 5: five nested calls into a four-entry stack
        step(16'hC020); step(16'hF000); chk_all("t5_c1", 16'h0020, 1'b0, 3'd1, 1'b0);
        step(16'hC030); step(16'hF000); chk_all("t5_c2", 16'h0030, 1'b0, 3'd2, 1'b0);
        step(16'hC040); step(16'hF000); chk_all("t5_c3", 16'h0040, 1'b0, 3'd3, 1'b0);
        step(16'hC050); step(16'hF000); chk_all("t5_c4", 16'h0050, 1'b0, 3'd4, 1'b0);
        step(16'hC060); chk("t5_c5_ctl", pc, 16'h0051);
        step(16'hF000); chk_all("t5_c5", 16'h0060, ERR_EN, 3'd4, ERR_EN);
`ifdef PCSEQ_STACK_ERR_EN
        step(16'h0001); chk_all("t5_frozen", 16'h0060, 1'b1, 3'd4, 1'b1);
        step(16'h1000); chk_all("t5_frozen2", 16'h0060, 1'b1, 3'd4, 1'b1);
`else
        step(16'h0001); chk_all("t5_r5", 16'h0052, 1'b0, 3'd3, 1'b0);
        step(16'h0001); chk_all("t5_r4", 16'h0042, 1'b0, 3'd2, 1'b0);
        step(16'h0001); chk_all("t5_r3", 16'h0032, 1'b0, 3'd1, 1'b0);
        step(16'h0001); chk_all("t5_r2", 16'h0022, 1'b0, 3'd0, 1'b0);
        step(16'h0001); chk_all("t5_uflow", 16'h0023, 1'b0, 3'd0, 1'b0);
`endif

        // Fresh start for the halt / async-reset scenario
        reset = 1'b0;
        #2;
        chk_all("rst2", 16'h0000, 1'b0, 3'd0, 1'b0);
        reset = 1'b1;

        // 6: halt and asynchronous reset while in WAIT
        step(16'hC010); step(16'hF000); chk_all("t6_call", 16'h0010, 1'b0, 3'd1, 1'b0);
        step(16'hE078); step(16'hF001); chk_all("t6_wait", 16'h0011, 1'b1, 3'd1, 1'b0);
        halt = 1'b1; cond_valid = 1'b1; cond_zero = 1'b1;
        step(16'hF001); chk_all("t6_halt1", 16'h0011, 1'b1, 3'd1, 1'b0);
        step(16'hF001); chk_all("t6_halt2", 16'h0011, 1'b1, 3'd1, 1'b0);
        halt = 1'b0; cond_valid = 1'b0; cond_zero = 1'b0;
        step(16'hF001); chk_all("t6_still", 16'h0011, 1'b1, 3'd1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk_all("t6_async", 16'h0000, 1'b0, 3'd0, 1'b0);
        #1;
        reset = 1'b1;

        // pc wrap at 16'hFFFF; cond_valid in RUN ignored
        step(16'hD0FF); chk("wrap_ctl", pc, 16'h0001);
        step(16'hF0FF); chk("wrap_tgt", pc, 16'hFFFF);
        cond_valid = 1'b1; cond_zero = 1'b1;
        step(16'h1000); chk_all("wrap_0", 16'h0000, 1'b0, 3'd0, 1'b0);
        cond_valid = 1'b0; cond_zero = 1'b0;

        // Malformed OPaddr word
        step(16'hD012); chk("bad_ctl", pc, 16'h0001);
        step(16'h1000); chk_all("bad_addr", 16'h0002, ERR_EN, 3'd0, ERR_EN);
        step(16'h1000); chk_all("bad_next", ERR_EN ? 16'h0002 : 16'h0003, ERR_EN, 3'd0, ERR_EN);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
